// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronizes and glitch-filters the pins, frames 11-bit bytes and
// resolves E0/F0 prefixes into single-cycle make/break strobes. Optional macro: TYPEMATIC_FILTER_EN.
`timescale 1ns/1ps
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int TO_W           = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_strobe,
  output logic       key_ext,
  output logic [7:0] brk_code,
  output logic       brk_strobe,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_t;
  typedef enum logic [1:0] {NORMAL, EXT, BRK, EXT_BRK} pfx_t;

  logic          clk_p0, clk_p1, dat_p0, dat_p1;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt, fall, dat_smp;
  frame_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TO_W-1:0] to_cnt;
  logic          byte_valid, frm_err;
  pfx_t          pfx, pfx_nxt;
  logic          emit_make, emit_brk, emit_ext, make_ok;
  logic          rec_vld, rec_ext;
  logic [7:0]    rec_code;

  // Stage p0/p1: two-flop synchronizers, idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      {clk_p0, clk_p1} <= 2'b11;
      {dat_p0, dat_p1} <= 2'b11;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt <= '0;
      clk_flt <= 1'b1;
      fall    <= 1'b0;
      dat_smp <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_p1 == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_flt <= clk_p1;
        flt_cnt <= '0;
        fall    <= clk_flt;
        dat_smp <= dat_p1;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    frm_err    = 1'b0;
    case (state)
      IDLE:   if (fall && !dat_smp) state_nxt = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY: if (fall) state_nxt = STOP;
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          if (dat_smp && (^{shreg, par})) byte_valid = 1'b1;
          else                            frm_err    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !fall && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = IDLE;
      frm_err   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg   <= {dat_smp, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par <= dat_smp;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pfx_nxt   = pfx;
    emit_make = 1'b0;
    emit_brk  = 1'b0;
    emit_ext  = 1'b0;
    if (frm_err) begin
      pfx_nxt = NORMAL;
    end else if (byte_valid) begin
      if (shreg == 8'h00 || shreg == 8'hAA || shreg == 8'hFA) begin
        pfx_nxt = NORMAL;
      end else if (shreg == 8'hE0) begin
        pfx_nxt = (pfx == EXT_BRK) ? EXT_BRK : EXT;
      end else if (shreg == 8'hF0) begin
        pfx_nxt = (pfx == EXT || pfx == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        pfx_nxt   = NORMAL;
        emit_ext  = (pfx == EXT) || (pfx == EXT_BRK);
        emit_brk  = (pfx == BRK) || (pfx == EXT_BRK);
        emit_make = !emit_brk;
      end
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  assign make_ok = emit_make && !(rec_vld && rec_ext == emit_ext && rec_code == shreg);
`else
  assign make_ok = emit_make;
`endif

  // Last delivered make; a matching break re-arms delivery of the same key
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_vld  <= 1'b0;
      rec_ext  <= 1'b0;
      rec_code <= '0;
    end else if (emit_make) begin
      rec_vld  <= 1'b1;
      rec_ext  <= emit_ext;
      rec_code <= shreg;
    end else if (emit_brk && rec_vld && rec_ext == emit_ext && rec_code == shreg) begin
      rec_vld <= 1'b0;
    end
  end

  // Output stage: registered strobes one cycle after the stop-bit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pfx        <= NORMAL;
      key_strobe <= 1'b0;
      key_code   <= '0;
      brk_strobe <= 1'b0;
      brk_code   <= '0;
      key_ext    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pfx        <= pfx_nxt;
      key_strobe <= make_ok;
      key_code   <= make_ok ? shreg : 8'h00;
      brk_strobe <= emit_brk;
      brk_code   <= emit_brk ? shreg : 8'h00;
      key_ext    <= (make_ok || emit_brk) && emit_ext;
      frame_err  <= frm_err;
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against an event-queue model of the
// prefix/typematic rules; build with or without TYPEMATIC_FILTER_EN.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
  localparam int H   = 12;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code, brk_code;
  logic       key_strobe, key_ext, brk_strobe, frame_err;

  ps2_key_decoder dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_strobe(key_strobe), .key_ext(key_ext),
    .brk_code(brk_code), .brk_strobe(brk_strobe), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         kind;   // 0 make, 1 break, 2 frame error
    logic [7:0] code;
    logic       ext;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0, n_fail = 0;
  int  n_make = 0, n_brk = 0, n_err = 0;
  logic [7:0] last_mk_code = 8'h00, last_bk_code = 8'h00;
  logic       last_mk_ext = 1'b0, last_bk_ext = 1'b0;
  bit  glitch_en = 0;

  // Model state: pending prefixes and last delivered make
  bit         m_ext = 0, m_brk = 0;
  bit         r_vld = 0, r_ext = 0;
  logic [7:0] r_code = 8'h00;

  function automatic void chk(input string nm, input int unsigned act, input int unsigned req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endfunction

  function automatic void push(input int kind, input logic [7:0] code, input logic ext);
    ev_t e;
    e.kind = kind; e.code = code; e.ext = ext;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; r_vld = 0;
  endfunction

  function automatic void model_err();
    push(2, 8'h00, 1'b0);
    m_ext = 0; m_brk = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      if (!(m_ext && m_brk)) begin m_ext = 1; m_brk = 0; end
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'h00 || b == 8'hAA || b == 8'hFA) begin
      m_ext = 0; m_brk = 0;
    end else begin
      if (m_brk) begin
        push(1, b, m_ext);
        if (r_vld && r_ext == m_ext && r_code == b) r_vld = 0;
      end else begin
`ifdef TYPEMATIC_FILTER_EN
        if (!(r_vld && r_ext == m_ext && r_code == b)) push(0, b, m_ext);
`else
        push(0, b, m_ext);
`endif
        r_vld = 1; r_ext = m_ext; r_code = b;
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // Compare process: every strobe must match the next expected event; codes idle at 0
  always @(negedge clk) begin
    if (!rst) begin
      if (key_strobe || brk_strobe || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {29'd0, key_strobe, brk_strobe, frame_err}, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_kind", key_strobe ? 0 : (brk_strobe ? 1 : 2), e.kind);
          if (key_strobe || brk_strobe) begin
            chk("event_code", key_strobe ? key_code : brk_code, e.code);
            chk("event_ext", key_ext, e.ext);
          end
        end
        chk("single_event", key_strobe + brk_strobe + frame_err, 1);
      end
      if (key_strobe) begin n_make++; last_mk_code = key_code; last_mk_ext = key_ext; end
      if (brk_strobe) begin n_brk++;  last_bk_code = brk_code; last_bk_ext = key_ext; end
      if (frame_err)  n_err++;
      if (!key_strobe) chk("key_code_idle", key_code, 0);
      if (!brk_strobe) chk("brk_code_idle", brk_code, 0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0 good, 1 flipped parity, 2 stop bit 0; only the first nbits bits are sent
  task automatic send_bits(input logic [7:0] b, input int mode, input int nbits);
    logic [10:0] bits;
    bits = {(mode != 2), (~^b) ^ (mode == 1), b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      wait_cyc(3);
      if (glitch_en && $urandom_range(0, 2) == 0) begin
        int g;
        g = $urandom_range(1, 3);
        ps2_clk = 1'b0;
        wait_cyc(g);
        ps2_clk = 1'b1;
        wait_cyc(H - 3 - g);
      end else begin
        wait_cyc(H - 3);
      end
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int mode);
    if (mode == 0) model_byte(b);
    else           model_err();
    send_bits(b, mode, 11);
    wait_cyc(GAP);
    chk("events_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(3);
    model_reset();
    exp_q.delete();
    rst = 1'b0;
  endtask

  int mk0, bk0, er0;

  initial begin
    wait_cyc(5);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_brk_code", brk_code, 8'h00);
    chk("rst_strobes", {key_strobe, brk_strobe, frame_err, key_ext}, 0);
    rst = 1'b0;
    wait_cyc(5);

    // Plain make
    mk0 = n_make;
    send_frame(8'h1B, 0);
    chk("make_1B_count", n_make - mk0, 1);
    chk("make_1B_code", last_mk_code, 8'h1B);
    chk("make_1B_ext", last_mk_ext, 0);

    // Break
    mk0 = n_make; bk0 = n_brk;
    send_frame(8'hF0, 0); send_frame(8'h1B, 0);
    chk("brk_1B_nomake", n_make - mk0, 0);
    chk("brk_1B_count", n_brk - bk0, 1);
    chk("brk_1B_code", last_bk_code, 8'h1B);
    chk("brk_1B_ext", last_bk_ext, 0);

    // Extended make and break
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    chk("ext_make_code", last_mk_code, 8'h75);
    chk("ext_make_ext", last_mk_ext, 1);
    bk0 = n_brk;
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    chk("ext_brk_count", n_brk - bk0, 1);
    chk("ext_brk_code", last_bk_code, 8'h75);
    chk("ext_brk_ext", last_bk_ext, 1);

    // Parity error, bad stop bit, then recovery
    mk0 = n_make; er0 = n_err;
    send_frame(8'h76, 1);
    chk("parity_err_count", n_err - er0, 1);
    chk("parity_err_nomake", n_make - mk0, 0);
    send_frame(8'h33, 2);
    chk("stop_err_count", n_err - er0, 2);
    send_frame(8'h4D, 0);
    chk("recover_4D", last_mk_code, 8'h4D);

    // Clock stalls after 4 data bits
    er0 = n_err;
    model_err();
    send_bits(8'h2D, 0, 5);
    wait_cyc(10100);
    chk("timeout_err_count", n_err - er0, 1);
    chk("timeout_drained", exp_q.size(), 0);
    mk0 = n_make;
    send_frame(8'h2D, 0);
    chk("after_timeout_2D", last_mk_code, 8'h2D);
    chk("after_timeout_count", n_make - mk0, 1);

    // Reset mid-frame
    er0 = n_err;
    send_bits(8'h2D, 0, 5);
    pulse_reset();
    chk("midrst_key_code", key_code, 8'h00);
    wait_cyc(10100);
    chk("midrst_no_err", n_err - er0, 0);
    mk0 = n_make;
    send_frame(8'h2D, 0);
    chk("midrst_decode_count", n_make - mk0, 1);
    chk("midrst_decode_code", last_mk_code, 8'h2D);

    // Typematic repeat
    pulse_reset();
    mk0 = n_make;
    send_frame(8'h1B, 0); send_frame(8'h1B, 0); send_frame(8'h1B, 0);
    send_frame(8'hF0, 0); send_frame(8'h1B, 0); send_frame(8'h1B, 0);
`ifdef TYPEMATIC_FILTER_EN
    chk("typematic_count", n_make - mk0, 2);
`else
    chk("typematic_count", n_make - mk0, 4);
`endif

    // Discarded codes clear a pending prefix
    mk0 = n_make;
    send_frame(8'hE0, 0); send_frame(8'hAA, 0); send_frame(8'h5A, 0);
    chk("discard_make_count", n_make - mk0, 1);
    chk("discard_make_ext", last_mk_ext, 0);

    // Randomized traffic with clock glitches
    glitch_en = 1;
    for (int i = 0; i < 110; i++) begin
      int r, mode;
      logic [7:0] b;
      logic [7:0] pool [4];
      logic [7:0] junk [3];
      pool = '{8'h1B, 8'h1C, 8'h75, 8'h6B};
      junk = '{8'h00, 8'hAA, 8'hFA};
      r = $urandom_range(0, 99);
      if      (r < 18) b = 8'hE0;
      else if (r < 36) b = 8'hF0;
      else if (r < 40) b = junk[$urandom_range(0, 2)];
      else if (r < 70) b = pool[$urandom_range(0, 3)];
      else             b = 8'($urandom);
      mode = ($urandom_range(0, 99) < 8) ? $urandom_range(1, 2) : 0;
      send_frame(b, mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
